decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides. It sits between the fetch stage and the register-read/execute stage. It extends the existing combinational function-code decode with:
- optional RV32M decode
- immediate generation and register-index extraction
- illegal-instruction flagging
- a two-entry skid buffer, so full throughput is kept under backpressure.

## Interface
Parameters:
- PC_W, 32, width of the program counter carried alongside the instruction
- M_EXT, 0, 1 = decode RV32M (MUL..REMU); 0 = treat those encodings as illegal
- FUNC_W, 6, width of the function-code field

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; registered
- in_iword  in  32  instruction word
- in_pc  in  PC_W  PC of in_iword
- out_valid  out  1  decoded entry present
- out_ready  in  1  downstream accepts
- out_func  out  FUNC_W  function code
- out_rd, out_rs1, out_rs2  out  5 each  register indices (iword[11:7], [19:15], [24:20])
- out_imm  out  32  sign-extended immediate
- out_rd_en  out  1  writes rd
- out_ld_en  out  1  is a load
- out_st_en  out  1  is a store
- out_illegal  out  1  unsupported encoding
- out_pc  out  PC_W  PC of the entry

## Operation
Function codes:
- 0–36 keep the established numbering: LUI=0, AUIPC=1, ADDI=2 … SRAI=10, ADD=11 … AND=20, JAL=21, JALR=22, BEQ=23 … BGEU=28, LB=29 … LHU=33, SB=34, SH=35, SW=36.
- With M_EXT=1: MUL=37, MULH=38, MULHSU=39, MULHU=40, DIV=41, DIVU=42, REM=43, REMU=44.
- ILLEGAL=63.

Illegal decode:
- Asserted for any opcode, funct3 or funct7 combination not listed above.
- This includes SLLI with funct7≠0, SRLI/SRAI with another funct7, and OP-type instructions with funct7 outside {0000000, 0100000, 0000001 (M_EXT only)}.
- When illegal: out_func=63, and out_rd_en, out_ld_en and out_st_en are all 0.

Immediate generation (sign-extended to 32 bits):
- I-type: OP-IMM, JALR, LOAD.
- S-type: STORE.
- B-type: BRANCH, with bit 0 = 0.
- U-type: LUI, AUIPC, as iword[31:12]<<12.
- J-type: JAL.
- R-type and illegal: 0.
- Shift-immediates: imm = {27'b0, shamt}.

Enable flags:
- rd_en = 1 for LUI, AUIPC, OP-IMM, OP, JAL, JALR and LOAD, and only when rd≠0. It is 0 for BRANCH, STORE and illegal.
- ld_en = 1 for legal LOAD.
- st_en = 1 for legal STORE.

Buffering:
- Main output register plus one skid register, each with its own valid bit.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- If an input transfer occurs while the main register is full and not draining, the decoded entry goes to the skid register.
- When the main register drains, the skid entry moves to main on that edge.
- Strict FIFO order; no entry is dropped or duplicated.
- in_ready = !skid_valid, taken from a register; no combinational path from out_ready to in_ready.

Flush:
- Clears both valid bits at the next edge.
- An input transfer in the same cycle is discarded.
- Flush has priority over every other event.

## Timing
- Latency: a word accepted at edge N is on the out_* ports with out_valid=1 after edge N.
- Throughput: 1 instruction per cycle while out_ready=1.
- After out_ready deasserts:
  - in_ready falls on the edge after the skid register fills, i.e. at most one extra word is accepted.
  - When out_ready returns, out_valid stays 1 and in_ready rises after the skid register drains.
- out_* payload is stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, in_ready=1, skid empty, and every payload output = 0 (including out_func=0 and out_pc=0).
- Reset asserted mid-stream discards all entries immediately. The first transfer is possible on the first edge after rst_n rises.
- Simultaneous drain and accept with the skid empty: main reloads with the new entry, and out_valid remains 1.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode localparams (LUI, AUIPC, OP_IMM, OP, JAL, JALR, BRANCH, LOAD, STORE)
  - all function-code constants, including FUNC_ILLEGAL=63
  - a packed struct `dec_t` {func, rd, rs1, rs2, imm, rd_en, ld_en, st_en, illegal, pc}
- One sub-module, `rv_decode_comb`: purely combinational, iword → `dec_t` fields, parametrised by M_EXT.
- `decode_stage` instantiates it once on in_iword and registers `dec_t` into the main and skid registers.

## Test plan
- ADDI x1,x0,5: 0x00500093 streamed with out_ready=1 → one cycle later out_func=2, out_rd=1, out_imm=5, out_rd_en=1, out_ld_en=0, out_st_en=0, out_illegal=0.
- SW x2,8(x1): 0x0020A423 → out_func=36, out_rs1=1, out_rs2=2, out_imm=8, out_st_en=1, out_rd_en=0.
- BEQ x0,x0,+8: 0x00000463 → out_func=23, out_imm=8, out_rd_en=0. Then the same word with iword[14:12]=010 → out_illegal=1, out_func=63.
- MUL x3,x1,x2: 0x022081B3 with M_EXT=1 → out_func=37, out_rd_en=1. With M_EXT=0 → out_func=63, out_illegal=1, out_rd_en=0.
- Backpressure: stream 8 distinct words with out_ready held 0 for 3 cycles mid-stream → in_ready low after the skid fills; all 8 emerge in order with no loss or duplication; payload stable while stalled.
- Flush and reset: with both entries full, pulse flush → out_valid=0 and in_ready=1 next cycle. Assert rst_n=0 mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: opcodes, function codes and the decoded-entry record.
package rv_decode_pkg;

    // Width of the pc field inside dec_t; the stage casts its own PC_W to and from this.
    localparam int PC_MAX_W = 64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [5:0] FUNC_LUI   = 6'd0,  FUNC_AUIPC = 6'd1;
    localparam logic [5:0] FUNC_ADDI  = 6'd2,  FUNC_SLTI  = 6'd3,  FUNC_SLTIU = 6'd4;
    localparam logic [5:0] FUNC_XORI  = 6'd5,  FUNC_ORI   = 6'd6,  FUNC_ANDI  = 6'd7;
    localparam logic [5:0] FUNC_SLLI  = 6'd8,  FUNC_SRLI  = 6'd9,  FUNC_SRAI  = 6'd10;
    localparam logic [5:0] FUNC_ADD   = 6'd11, FUNC_SUB   = 6'd12, FUNC_SLL   = 6'd13;
    localparam logic [5:0] FUNC_SLT   = 6'd14, FUNC_SLTU  = 6'd15, FUNC_XOR   = 6'd16;
    localparam logic [5:0] FUNC_SRL   = 6'd17, FUNC_SRA   = 6'd18, FUNC_OR    = 6'd19;
    localparam logic [5:0] FUNC_AND   = 6'd20, FUNC_JAL   = 6'd21, FUNC_JALR  = 6'd22;
    localparam logic [5:0] FUNC_BEQ   = 6'd23, FUNC_BNE   = 6'd24, FUNC_BLT   = 6'd25;
    localparam logic [5:0] FUNC_BGE   = 6'd26, FUNC_BLTU  = 6'd27, FUNC_BGEU  = 6'd28;
    localparam logic [5:0] FUNC_LB    = 6'd29, FUNC_LH    = 6'd30, FUNC_LW    = 6'd31;
    localparam logic [5:0] FUNC_LBU   = 6'd32, FUNC_LHU   = 6'd33;
    localparam logic [5:0] FUNC_SB    = 6'd34, FUNC_SH    = 6'd35, FUNC_SW    = 6'd36;
    localparam logic [5:0] FUNC_MUL   = 6'd37, FUNC_MULH  = 6'd38, FUNC_MULHSU = 6'd39;
    localparam logic [5:0] FUNC_MULHU = 6'd40, FUNC_DIV   = 6'd41, FUNC_DIVU  = 6'd42;
    localparam logic [5:0] FUNC_REM   = 6'd43, FUNC_REMU  = 6'd44;
    localparam logic [5:0] FUNC_ILLEGAL = 6'd63;

    typedef struct packed {
        logic [5:0]          func;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic                rd_en;
        logic                ld_en;
        logic                st_en;
        logic                illegal;
        logic [PC_MAX_W-1:0] pc;
    } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word to dec_t (pc left at zero).
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int M_EXT = 0
) (
    input  logic [31:0] iword,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [5:0]  func;
    logic [31:0] imm;
    logic        legal, writes_rd, is_load, is_store;

    assign opcode = iword[6:0];
    assign funct3 = iword[14:12];
    assign funct7 = iword[31:25];
    assign rd     = iword[11:7];
    assign imm_i  = {{20{iword[31]}}, iword[31:20]};
    assign imm_s  = {{20{iword[31]}}, iword[31:25], iword[11:7]};
    assign imm_b  = {{19{iword[31]}}, iword[31], iword[7], iword[30:25], iword[11:8], 1'b0};
    assign imm_u  = {iword[31:12], 12'h000};
    assign imm_j  = {{11{iword[31]}}, iword[31], iword[19:12], iword[20], iword[30:21], 1'b0};
    assign imm_sh = {27'b0, iword[24:20]};

    // Classify the encoding into a function code, immediate format and class flags
    always_comb begin
        func      = FUNC_ILLEGAL;
        imm       = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (opcode)
            OPC_LUI:   begin func = FUNC_LUI;   imm = imm_u; legal = 1'b1; writes_rd = 1'b1; end
            OPC_AUIPC: begin func = FUNC_AUIPC; imm = imm_u; legal = 1'b1; writes_rd = 1'b1; end
            OPC_JAL:   begin func = FUNC_JAL;   imm = imm_j; legal = 1'b1; writes_rd = 1'b1; end
            OPC_JALR: begin
                func      = FUNC_JALR;
                imm       = imm_i;
                writes_rd = 1'b1;
                legal     = (funct3 == 3'b000);
            end
            OPC_OP_IMM: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
                case (funct3)
                    3'b000: func = FUNC_ADDI;
                    3'b010: func = FUNC_SLTI;
                    3'b011: func = FUNC_SLTIU;
                    3'b100: func = FUNC_XORI;
                    3'b110: func = FUNC_ORI;
                    3'b111: func = FUNC_ANDI;
                    3'b001: begin
                        func  = FUNC_SLLI;
                        imm   = imm_sh;
                        legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        imm = imm_sh;
                        if (funct7 == F7_BASE)     func = FUNC_SRLI;
                        else if (funct7 == F7_ALT) func = FUNC_SRAI;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  func = FUNC_ADD;
                        3'b001:  func = FUNC_SLL;
                        3'b010:  func = FUNC_SLT;
                        3'b011:  func = FUNC_SLTU;
                        3'b100:  func = FUNC_XOR;
                        3'b101:  func = FUNC_SRL;
                        3'b110:  func = FUNC_OR;
                        default: func = FUNC_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  func = FUNC_SUB;
                        3'b101:  func = FUNC_SRA;
                        default: legal = 1'b0;
                    endcase
                end else if (M_EXT != 0 && funct7 == F7_MULDIV) begin
                    func = FUNC_MUL + {3'b000, funct3};
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                legal = 1'b1;
                imm   = imm_b;
                case (funct3)
                    3'b000:  func = FUNC_BEQ;
                    3'b001:  func = FUNC_BNE;
                    3'b100:  func = FUNC_BLT;
                    3'b101:  func = FUNC_BGE;
                    3'b110:  func = FUNC_BLTU;
                    3'b111:  func = FUNC_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm       = imm_i;
                case (funct3)
                    3'b000:  func = FUNC_LB;
                    3'b001:  func = FUNC_LH;
                    3'b010:  func = FUNC_LW;
                    3'b100:  func = FUNC_LBU;
                    3'b101:  func = FUNC_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                legal    = 1'b1;
                is_store = 1'b1;
                imm      = imm_s;
                case (funct3)
                    3'b000:  func = FUNC_SB;
                    3'b001:  func = FUNC_SH;
                    3'b010:  func = FUNC_SW;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the record; an illegal encoding has no immediate and no side effects
    always_comb begin
        dec         = '0;
        dec.func    = legal ? func : FUNC_ILLEGAL;
        dec.rd      = rd;
        dec.rs1     = iword[19:15];
        dec.rs2     = iword[24:20];
        dec.imm     = legal ? imm : 32'h0;
        dec.rd_en   = legal && writes_rd && (rd != 5'd0);
        dec.ld_en   = legal && is_load;
        dec.st_en   = legal && is_store;
        dec.illegal = !legal;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a main output register plus one skid register.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int M_EXT  = 0,
    parameter int FUNC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_iword,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] out_func,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic              out_rd_en,
    output logic              out_ld_en,
    output logic              out_st_en,
    output logic              out_illegal,
    output logic [PC_W-1:0]   out_pc
);

    dec_t decoded, entry, main_q, skid_q;
    logic main_valid, skid_valid, in_fire, out_fire;

    rv_decode_comb #(.M_EXT(M_EXT)) u_decode (
        .iword (in_iword),
        .dec   (decoded)
    );

    // Attach the fetch PC to the decoded record
    always_comb begin
        entry    = decoded;
        entry.pc = PC_MAX_W'(in_pc);
    end

    // Ready depends only on the skid flop, so out_ready never reaches in_ready combinationally
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid && out_ready;

    // Main register: refill from skid first to keep order, else from the decoder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (out_fire || !main_valid) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
            end else if (in_fire) begin
                main_q     <= entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    // Skid register: catches the word accepted while main is full and stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_fire) skid_valid <= 1'b0;
        end else if (in_fire && main_valid && !out_fire) begin
            skid_q     <= entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_func    = FUNC_W'(main_q.func);
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_rd_en   = main_q.rd_en;
    assign out_ld_en   = main_q.ld_en;
    assign out_st_en   = main_q.st_en;
    assign out_illegal = main_q.illegal;
    assign out_pc      = PC_W'(main_q.pc);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench: two stages (M_EXT=1 and M_EXT=0) share stimulus and are
// compared against a table-driven decode model and an occupancy/FIFO scoreboard.
module tb_decode_stage;

    localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;

    typedef struct packed {
        logic [5:0]  func;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        rd_en;
        logic        ld_en;
        logic        st_en;
        logic        illegal;
        logic [31:0] pc;
    } rec_t;

    typedef struct {
        int opc;
        int f3;
        int f7;
        int code;
        int fmt;
        bit m;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_iword, in_pc;

    logic        m_in_ready, m_out_valid, m_out_rd_en, m_out_ld_en, m_out_st_en, m_out_illegal;
    logic [5:0]  m_out_func;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [31:0] m_out_imm, m_out_pc;
    logic        b_in_ready, b_out_valid, b_out_rd_en, b_out_ld_en, b_out_st_en, b_out_illegal;
    logic [5:0]  b_out_func;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [31:0] b_out_imm, b_out_pc;

    int   checks = 0;
    int   passed = 0;
    row_t tbl[$];
    rec_t qm[$];
    rec_t qb[$];

    always #5 clk = ~clk;

    decode_stage #(.PC_W(32), .M_EXT(1), .FUNC_W(6)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_iword(in_iword), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_func(m_out_func), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_imm(m_out_imm), .out_rd_en(m_out_rd_en), .out_ld_en(m_out_ld_en),
        .out_st_en(m_out_st_en), .out_illegal(m_out_illegal), .out_pc(m_out_pc)
    );

    decode_stage #(.PC_W(32), .M_EXT(0), .FUNC_W(6)) dut_base (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_iword(in_iword), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_func(b_out_func), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_imm(b_out_imm), .out_rd_en(b_out_rd_en), .out_ld_en(b_out_ld_en),
        .out_st_en(b_out_st_en), .out_illegal(b_out_illegal), .out_pc(b_out_pc)
    );

    function automatic rec_t got_m();
        return {m_out_func, m_out_rd, m_out_rs1, m_out_rs2, m_out_imm,
                m_out_rd_en, m_out_ld_en, m_out_st_en, m_out_illegal, m_out_pc};
    endfunction

    function automatic rec_t got_b();
        return {b_out_func, b_out_rd, b_out_rs1, b_out_rs2, b_out_imm,
                b_out_rd_en, b_out_ld_en, b_out_st_en, b_out_illegal, b_out_pc};
    endfunction

    function automatic void add(int opc, int f3, int f7, int code, int fmt, bit m = 1'b0);
        row_t r;
        r = '{opc, f3, f7, code, fmt, m};
        tbl.push_back(r);
    endfunction

    // Instruction table in function-code order; -1 means "any value"
    function automatic void build_table();
        int immf3[6];
        int opf3[10];
        int opf7[10];
        int brf3[6];
        int ldf3[5];
        immf3 = '{0, 2, 3, 4, 6, 7};
        opf3  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        opf7  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        brf3  = '{0, 1, 4, 5, 6, 7};
        ldf3  = '{0, 1, 2, 4, 5};
        add('h37, -1, -1, 0, F_U);
        add('h17, -1, -1, 1, F_U);
        for (int i = 0; i < 6; i++) add('h13, immf3[i], -1, 2 + i, F_I);
        add('h13, 1, 0, 8, F_SH);
        add('h13, 5, 0, 9, F_SH);
        add('h13, 5, 32, 10, F_SH);
        for (int i = 0; i < 10; i++) add('h33, opf3[i], opf7[i], 11 + i, F_R);
        add('h6f, -1, -1, 21, F_J);
        add('h67, 0, -1, 22, F_I);
        for (int i = 0; i < 6; i++) add('h63, brf3[i], -1, 23 + i, F_B);
        for (int i = 0; i < 5; i++) add('h03, ldf3[i], -1, 29 + i, F_I);
        for (int i = 0; i < 3; i++) add('h23, i, -1, 34 + i, F_S);
        for (int i = 0; i < 8; i++) add('h33, i, 1, 37 + i, F_R, 1'b1);
    endfunction

    // Reference decode: look the word up in the table, then build fields by format
    function automatic rec_t ref_decode(logic [31:0] w, logic [31:0] pc, bit m_ext);
        rec_t r;
        int   hit;
        hit       = -1;
        r         = '0;
        r.rd      = w[11:7];
        r.rs1     = w[19:15];
        r.rs2     = w[24:20];
        r.pc      = pc;
        r.func    = 6'd63;
        r.illegal = 1'b1;
        foreach (tbl[i]) begin
            if (hit < 0 && tbl[i].opc == int'(w[6:0]) &&
                (tbl[i].f3 < 0 || tbl[i].f3 == int'(w[14:12])) &&
                (tbl[i].f7 < 0 || tbl[i].f7 == int'(w[31:25])) &&
                (!tbl[i].m || m_ext))
                hit = i;
        end
        if (hit >= 0) begin
            r.illegal = 1'b0;
            r.func    = 6'(tbl[hit].code);
            case (tbl[hit].fmt)
                F_I:     r.imm = 32'($signed(w[31:20]));
                F_SH:    r.imm = 32'(w[24:20]);
                F_S:     r.imm = 32'($signed({w[31:25], w[11:7]}));
                F_B:     r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                F_U:     r.imm = {w[31:12], 12'h000};
                F_J:     r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                default: r.imm = 32'h0;
            endcase
            r.rd_en = (tbl[hit].opc != 'h63) && (tbl[hit].opc != 'h23) && (w[11:7] != 5'd0);
            r.ld_en = (tbl[hit].opc == 'h03);
            r.st_en = (tbl[hit].opc == 'h23);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        row_t        r;
        w = $urandom;
        if ($urandom_range(0, 9) < 2) return w;
        r = tbl[$urandom_range(0, tbl.size() - 1)];
        w[6:0] = 7'(r.opc);
        if (r.f3 >= 0) w[14:12] = 3'(r.f3);
        if (r.f7 >= 0) w[31:25] = 7'(r.f7);
        return w;
    endfunction

    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] pc);
        @(negedge clk);
        in_valid  = 1'b1;
        in_iword  = word;
        in_pc     = pc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_iword  = 32'h0;
        in_pc     = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_out_valid, m_in_ready, got_m(), b_out_valid, b_in_ready, got_b()} !==
            {1'b0, 1'b1, rec_t'(0), 1'b0, 1'b1, rec_t'(0)})
            $display("[TB] FAIL reset_state: got m=%b/%b %h b=%b/%b %h expected valid=0 ready=1 payload=0",
                     m_out_valid, m_in_ready, got_m(), b_out_valid, b_in_ready, got_b());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known_words();
        applyStimulus(32'h00500093, 32'h100);
        checks++;
        if ({m_out_valid, m_out_func, m_out_rd, m_out_imm, m_out_rd_en, m_out_ld_en, m_out_st_en, m_out_illegal} !==
            {1'b1, 6'd2, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL addi: got func=%0d rd=%0d imm=%h en=%b%b%b ill=%b v=%b expected func=2 rd=1 imm=5 en=100 ill=0",
                     m_out_func, m_out_rd, m_out_imm, m_out_rd_en, m_out_ld_en, m_out_st_en, m_out_illegal, m_out_valid);
        else passed++;
        checks++;
        if (got_m() !== ref_decode(32'h00500093, 32'h100, 1'b1))
            $display("[TB] FAIL addi_model: got %h expected %h", got_m(), ref_decode(32'h00500093, 32'h100, 1'b1));
        else passed++;

        applyStimulus(32'h0020A423, 32'h104);
        checks++;
        if ({m_out_valid, m_out_func, m_out_rs1, m_out_rs2, m_out_imm, m_out_st_en, m_out_rd_en} !==
            {1'b1, 6'd36, 5'd1, 5'd2, 32'd8, 1'b1, 1'b0})
            $display("[TB] FAIL sw: got func=%0d rs1=%0d rs2=%0d imm=%h st=%b rd_en=%b expected 36/1/2/8/1/0",
                     m_out_func, m_out_rs1, m_out_rs2, m_out_imm, m_out_st_en, m_out_rd_en);
        else passed++;

        applyStimulus(32'h00000463, 32'h108);
        checks++;
        if ({m_out_valid, m_out_func, m_out_imm, m_out_rd_en, m_out_illegal} !== {1'b1, 6'd23, 32'd8, 1'b0, 1'b0})
            $display("[TB] FAIL beq: got func=%0d imm=%h rd_en=%b ill=%b expected 23/8/0/0",
                     m_out_func, m_out_imm, m_out_rd_en, m_out_illegal);
        else passed++;

        applyStimulus(32'h00002463, 32'h10c);
        checks++;
        if ({m_out_valid, m_out_func, m_out_illegal, m_out_imm, m_out_rd_en} !== {1'b1, 6'd63, 1'b1, 32'd0, 1'b0})
            $display("[TB] FAIL beq_bad_funct3: got func=%0d ill=%b imm=%h rd_en=%b expected 63/1/0/0",
                     m_out_func, m_out_illegal, m_out_imm, m_out_rd_en);
        else passed++;

        applyStimulus(32'h022081B3, 32'h110);
        checks++;
        if ({m_out_func, m_out_rd_en, m_out_illegal} !== {6'd37, 1'b1, 1'b0})
            $display("[TB] FAIL mul_mext1: got func=%0d rd_en=%b ill=%b expected 37/1/0",
                     m_out_func, m_out_rd_en, m_out_illegal);
        else passed++;
        checks++;
        if ({b_out_func, b_out_rd_en, b_out_illegal} !== {6'd63, 1'b0, 1'b1})
            $display("[TB] FAIL mul_mext0: got func=%0d rd_en=%b ill=%b expected 63/0/1",
                     b_out_func, b_out_rd_en, b_out_illegal);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] words[8];
        logic [31:0] pcs[8];
        int   sent, recv, c;
        bit   saw_low, last_stalled;
        rec_t last;
        for (int i = 0; i < 8; i++) begin
            words[i] = {12'(i * 7 + 1), 5'd0, 3'b000, 5'(i + 1), 7'h13};
            pcs[i]   = 32'h200 + 32'(4 * i);
        end
        sent = 0; recv = 0; c = 0; saw_low = 1'b0; last_stalled = 1'b0; last = '0;
        while (recv < 8 && c < 40) begin
            @(negedge clk);
            checks++;
            if ({m_out_valid, m_in_ready} !== {(sent - recv) > 0, (sent - recv) < 2})
                $display("[TB] FAIL bp_occupancy: got valid=%b ready=%b expected for %0d held",
                         m_out_valid, m_in_ready, sent - recv);
            else passed++;
            if (!m_in_ready) saw_low = 1'b1;
            if (last_stalled) begin
                checks++;
                if (got_m() !== last) $display("[TB] FAIL bp_stable: got %h expected %h", got_m(), last);
                else passed++;
            end
            out_ready = !(c >= 2 && c < 5);
            in_valid  = (sent < 8);
            in_iword  = (sent < 8) ? words[sent] : 32'h0;
            in_pc     = (sent < 8) ? pcs[sent] : 32'h0;
            if (m_out_valid && out_ready) begin
                checks++;
                if (got_m() !== ref_decode(words[recv], pcs[recv], 1'b1))
                    $display("[TB] FAIL bp_order: got %h expected %h", got_m(), ref_decode(words[recv], pcs[recv], 1'b1));
                else passed++;
                recv++;
            end
            last_stalled = m_out_valid && !out_ready;
            last         = got_m();
            if (in_valid && m_in_ready) sent++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv !== 8) $display("[TB] FAIL bp_drain_timeout: got %0d words expected 8", recv);
        else passed++;
        checks++;
        if (saw_low !== 1'b1) $display("[TB] FAIL bp_ready_low: got in_ready never low expected low once skid full");
        else passed++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_iword = 32'h00100113; in_pc = 32'h300;
        @(negedge clk);
        in_iword = 32'h00200193; in_pc = 32'h304;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({m_out_valid, m_in_ready} !== 2'b10)
            $display("[TB] FAIL flush_setup: got valid=%b ready=%b expected 1/0", m_out_valid, m_in_ready);
        else passed++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({m_out_valid, m_in_ready, b_out_valid, b_in_ready} !== 4'b0101)
            $display("[TB] FAIL flush_full: got valid=%b ready=%b expected 0/1", m_out_valid, m_in_ready);
        else passed++;
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_iword = 32'h00300213;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({m_out_valid, m_in_ready} !== 2'b01)
            $display("[TB] FAIL flush_discard_input: got valid=%b ready=%b expected 0/1", m_out_valid, m_in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_stream();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_iword = 32'h123452b7; in_pc = 32'h400;
        @(negedge clk);
        in_iword = 32'h00a00313; in_pc = 32'h404;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_out_valid, m_in_ready, got_m()} !== {1'b0, 1'b1, rec_t'(0)})
            $display("[TB] FAIL reset_async: got valid=%b ready=%b %h expected 0/1 payload 0",
                     m_out_valid, m_in_ready, got_m());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_iword = 32'hfff00393; in_pc = 32'h408;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({m_out_valid, got_m()} !== {1'b1, ref_decode(32'hfff00393, 32'h408, 1'b1)})
            $display("[TB] FAIL reset_first_transfer: got valid=%b %h expected 1 %h",
                     m_out_valid, got_m(), ref_decode(32'hfff00393, 32'h408, 1'b1));
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ev, er;
        qm.delete();
        qb.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            ev = (qm.size() != 0);
            er = (qm.size() < 2);
            checks++;
            if ({m_out_valid, m_in_ready, b_out_valid, b_in_ready} !== {ev, er, ev, er})
                $display("[TB] FAIL rand_occupancy: got m=%b%b b=%b%b expected valid=%b ready=%b",
                         m_out_valid, m_in_ready, b_out_valid, b_in_ready, ev, er);
            else passed++;
            if (m_out_valid && qm.size() > 0) begin
                checks++;
                if (got_m() !== qm[0] || got_b() !== qb[0])
                    $display("[TB] FAIL rand_payload: got m=%h b=%h expected m=%h b=%h", got_m(), got_b(), qm[0], qb[0]);
                else passed++;
            end
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_iword  = rand_word();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if (flush) begin
                qm.delete();
                qb.delete();
            end else begin
                if (m_out_valid && out_ready && qm.size() > 0) begin
                    void'(qm.pop_front());
                    void'(qb.pop_front());
                end
                if (in_valid && m_in_ready) begin
                    qm.push_back(ref_decode(in_iword, in_pc, 1'b1));
                    qb.push_back(ref_decode(in_iword, in_pc, 1'b0));
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && qm.size() > 0; k++) begin
            @(negedge clk);
            checks++;
            if (!m_out_valid || got_m() !== qm[0] || got_b() !== qb[0])
                $display("[TB] FAIL rand_drain: got v=%b m=%h expected %h", m_out_valid, got_m(), qm[0]);
            else passed++;
            void'(qm.pop_front());
            void'(qb.pop_front());
        end
        @(negedge clk);
        checks++;
        if ({qm.size() == 0, m_out_valid, m_in_ready} !== 3'b101)
            $display("[TB] FAIL rand_empty: got left=%0d valid=%b ready=%b expected 0/0/1",
                     qm.size(), m_out_valid, m_in_ready);
        else passed++;
    endtask

    initial begin
        build_table();
        test_reset();
        test_known_words();
        test_backpressure();
        test_flush();
        test_reset_mid_stream();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
